// File: rtl/ln_cu.sv
`default_nettype none
// ============================================================================
//  Module      : ln_cu
//  Description : Control unit for the single-precision ln(1+x) accelerator.
//                Latches the operand, range-checks it, and sequences a Horner
//                evaluation of ln(1+x) over an external FP multiplier, FP
//                adder and accumulator. Handshake: start / done / ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module ln_cu #(
    parameter int N_TERMS = 8,
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        res,
    input  logic [31:0] num,
    input  logic        start,
    input  logic        ack,
    output logic [31:0] x,
    output logic [31:0] cf,
    output logic        m0,
    output logic        ld_acc,
    output logic        resM,
    output logic        resA,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // Elaboration-time parameter guards
    if (N_TERMS < 2 || N_TERMS > 8) begin : g_bad_n_terms
        $error("ln_cu: N_TERMS must be in 2..8");
    end
    if (MUL_LAT < 1 || MUL_LAT > 4) begin : g_bad_mul_lat
        $error("ln_cu: MUL_LAT must be in 1..4");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SEED = 3'd2,
        S_MUL  = 3'd3,
        S_ADD  = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    localparam logic [3:0] C_NTERMS  = 4'(N_TERMS);
    localparam logic [2:0] C_K_START = 3'(N_TERMS - 1);
    localparam logic [1:0] C_MUL_END = 2'(MUL_LAT - 1);

    state_t      state;
    logic [2:0]  k;      // current Horner coefficient index
    logic [1:0]  cnt;    // cycles spent in MUL so far

    // Series coefficients c_k = (-1)^(k+1)/k; index 0 is the final "+0" pass
    function automatic logic [31:0] coef(input logic [3:0] idx);
        logic [31:0] c;
        case (idx)
            4'd1:    c = 32'h3F800000;
            4'd2:    c = 32'hBF000000;
            4'd3:    c = 32'h3EAAAAAB;
            4'd4:    c = 32'hBE800000;
            4'd5:    c = 32'h3E4CCCCD;
            4'd6:    c = 32'hBE2AAAAB;
            4'd7:    c = 32'h3E124925;
            4'd8:    c = 32'hBE000000;
            default: c = 32'h00000000;
        endcase
        return c;
    endfunction

    // Sequencer: state and all outputs are registered together
    always_ff @(posedge clk) begin
        if (!res) begin
            state  <= S_IDLE;
            k      <= 3'd0;
            cnt    <= 2'd0;
            x      <= 32'h0;
            cf     <= 32'h0;
            m0     <= 1'b0;
            ld_acc <= 1'b0;
            resM   <= 1'b1;
            resA   <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ld_acc <= 1'b0;
                    m0     <= 1'b0;
                    if (start) begin
                        // Datapath clears are issued for the LOAD cycle only
                        x     <= num;
                        busy  <= 1'b1;
                        resM  <= 1'b1;
                        resA  <= 1'b1;
                        state <= S_LOAD;
                    end else begin
                        resM <= 1'b0;
                        resA <= 1'b0;
                    end
                end

                S_LOAD: begin
                    resM <= 1'b0;
                    resA <= 1'b0;
                    // |x| < 1 exactly when the biased exponent is below 127
                    if (x[30:23] < 8'd127) begin
                        cf     <= coef(C_NTERMS);
                        m0     <= 1'b0;
                        ld_acc <= 1'b1;
                        state  <= S_SEED;
                    end else begin
                        cf    <= 32'h0;
                        m0    <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= S_ERR;
                    end
                end

                S_SEED: begin
                    // Accumulator now holds c_N; start multiply passes
                    k      <= C_K_START;
                    cnt    <= 2'd0;
                    cf     <= coef({1'b0, C_K_START});
                    m0     <= 1'b1;
                    ld_acc <= 1'b0;
                    state  <= S_MUL;
                end

                S_MUL: begin
                    if (cnt == C_MUL_END) begin
                        ld_acc <= 1'b1;
                        state  <= S_ADD;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end

                S_ADD: begin
                    ld_acc <= 1'b0;
                    if (k != 3'd0) begin
                        k     <= k - 3'd1;
                        cnt   <= 2'd0;
                        cf    <= coef({1'b0, k - 3'd1});
                        state <= S_MUL;
                    end else begin
                        cf    <= 32'h0;
                        m0    <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end

                S_DONE, S_ERR: begin
                    // A start arriving with ack is deliberately dropped
                    if (ack) begin
                        done  <= 1'b0;
                        err   <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ln_cu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ln_cu
//  Description : Directed self-checking bench for ln_cu (default config plus
//                an N_TERMS=2 / MUL_LAT=3 instance).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ln_cu;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic [31:0] num = 32'h0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        ack = 1'b0;

    logic [31:0] x, cf, x2, cf2;
    logic        m0, ld_acc, resM, resA, busy, done, err;
    logic        m02, ld_acc2, resM2, resA2, busy2, done2, err2;

    int checks = 0;
    int failures = 0;

    // Observations captured by run_op
    logic [31:0] p_cf [0:15];
    logic        p_m0 [0:15];
    int          p_t  [0:15];
    int          np;
    int          done_t;
    logic        x_moved, rst_seen, err_seen;

    logic [31:0] exp8 [0:8] = '{32'hBE000000, 32'h3E124925, 32'hBE2AAAAB,
                                32'h3E4CCCCD, 32'hBE800000, 32'h3EAAAAAB,
                                32'hBF000000, 32'h3F800000, 32'h00000000};
    logic [31:0] exp2 [0:2] = '{32'hBF000000, 32'h3F800000, 32'h00000000};

    ln_cu dut (
        .clk(clk), .res(res), .num(num), .start(start), .ack(ack),
        .x(x), .cf(cf), .m0(m0), .ld_acc(ld_acc), .resM(resM), .resA(resA),
        .busy(busy), .done(done), .err(err)
    );

    ln_cu #(.N_TERMS(2), .MUL_LAT(3)) dut2 (
        .clk(clk), .res(res), .num(num), .start(start2), .ack(ack),
        .x(x2), .cf(cf2), .m0(m02), .ld_acc(ld_acc2), .resM(resM2), .resA(resA2),
        .busy(busy2), .done(done2), .err(err2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one operation on dut and record ld_acc pulses until done (bounded)
    task automatic run_op(input logic [31:0] operand, input int inject_t);
        np = 0; done_t = -1; x_moved = 1'b0; rst_seen = 1'b0; err_seen = 1'b0;
        num = operand; start = 1'b1;
        tick();
        start = 1'b0;
        num = 32'hDEADBEEF;
        for (int t = 1; t <= 40; t++) begin
            if (t == inject_t) start = 1'b1;
            tick();
            start = 1'b0;
            if (ld_acc && np < 16) begin
                p_cf[np] = cf; p_m0[np] = m0; p_t[np] = t; np++;
            end
            if (x !== operand) x_moved = 1'b1;
            if (resM || resA) rst_seen = 1'b1;
            if (done) begin
                done_t = t; err_seen = err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        res = 1'b0;
        tick(); tick();
        checks++; if ({x, cf} !== 64'h0) begin failures++; $display("FAIL reset_xcf got %h req 0", {x, cf}); end
        checks++; if ({m0, ld_acc, busy, done, err} !== 5'b0) begin failures++; $display("FAIL reset_flags got %b req 00000", {m0, ld_acc, busy, done, err}); end
        checks++; if ({resM, resA} !== 2'b11) begin failures++; $display("FAIL reset_clr got %b req 11", {resM, resA}); end
        res = 1'b1;
        tick();
        checks++; if ({resM, resA, busy, done} !== 4'b0) begin failures++; $display("FAIL reset_release got %b req 0000", {resM, resA, busy, done}); end
    endtask

    task automatic check_valid_run(input string tag);
        checks++; if (done_t !== 18) begin failures++; $display("FAIL %s_latency got %0d req 18", tag, done_t); end
        checks++; if (np !== 9) begin failures++; $display("FAIL %s_pulses got %0d req 9", tag, np); end
        for (int i = 0; i < 9 && i < np; i++) begin
            checks++; if (p_cf[i] !== exp8[i]) begin failures++; $display("FAIL %s_cf[%0d] got %h req %h", tag, i, p_cf[i], exp8[i]); end
            checks++; if (p_m0[i] !== (i != 0)) begin failures++; $display("FAIL %s_m0[%0d] got %b req %b", tag, i, p_m0[i], (i != 0)); end
        end
        checks++; if (err_seen !== 1'b0) begin failures++; $display("FAIL %s_err got %b req 0", tag, err_seen); end
        checks++; if (x_moved !== 1'b0) begin failures++; $display("FAIL %s_x_stable got moved req stable", tag); end
        checks++; if (rst_seen !== 1'b0) begin failures++; $display("FAIL %s_clr_after_load got 1 req 0", tag); end
    endtask

    task automatic test_valid_half();
        num = 32'h3F000000; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({busy, resM, resA, ld_acc} !== 4'b1110) begin failures++; $display("FAIL load_cycle got %b req 1110", {busy, resM, resA, ld_acc}); end
        // finish this one, then rerun through the collector
        ack = 1'b0;
        for (int t = 0; t < 40 && !done; t++) tick();
        ack = 1'b1; tick(); ack = 1'b0;
        run_op(32'h3F000000, 0);
        check_valid_run("half");
        ack = 1'b1; tick(); ack = 1'b0;
        checks++; if ({done, busy} !== 2'b00) begin failures++; $display("FAIL half_ack got %b req 00", {done, busy}); end
    endtask

    task automatic test_range_error();
        logic [31:0] bad [0:1] = '{32'h3F800000, 32'h7FC00000};
        for (int i = 0; i < 2; i++) begin
            num = bad[i]; start = 1'b1;
            tick();
            start = 1'b0;
            checks++; if ({done, ld_acc} !== 2'b00) begin failures++; $display("FAIL err_load[%0d] got %b req 00", i, {done, ld_acc}); end
            tick();
            checks++; if ({done, err, busy, ld_acc} !== 4'b1100) begin failures++; $display("FAIL err_flags[%0d] got %b req 1100", i, {done, err, busy, ld_acc}); end
            ack = 1'b1; tick(); ack = 1'b0;
            checks++; if ({done, err} !== 2'b00) begin failures++; $display("FAIL err_ack[%0d] got %b req 00", i, {done, err}); end
        end
    endtask

    task automatic test_hold_and_ignore();
        int held;
        run_op(32'h3F000000, 5);
        check_valid_run("inject");
        held = 0;
        for (int t = 0; t < 10; t++) begin
            if (t == 3) start = 1'b1;
            tick();
            start = 1'b0;
            if (done && !busy && x === 32'h3F000000) held++;
        end
        checks++; if (held !== 10) begin failures++; $display("FAIL done_hold got %0d req 10", held); end
        ack = 1'b1; start = 1'b1; num = 32'h3E000000;
        tick();
        ack = 1'b0; start = 1'b0;
        checks++; if ({done, busy} !== 2'b00) begin failures++; $display("FAIL ack_start_same got %b req 00", {done, busy}); end
        tick();
        checks++; if ({busy, resM} !== 2'b00) begin failures++; $display("FAIL start_dropped got %b req 00", {busy, resM}); end
    endtask

    task automatic test_reset_mid_run();
        num = 32'h3F000000; start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 10; t++) tick();   // now in the 5th MUL cycle
        res = 1'b0;
        tick();
        checks++; if ({busy, ld_acc, done} !== 3'b000) begin failures++; $display("FAIL midrst_flags got %b req 000", {busy, ld_acc, done}); end
        checks++; if (cf !== 32'h0) begin failures++; $display("FAIL midrst_cf got %h req 0", cf); end
        res = 1'b1;
        tick();
        run_op(32'h3F000000, 0);
        check_valid_run("after_rst");
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic test_small_config();
        int n2, d2;
        logic [31:0] c2 [0:3];
        int t2 [0:3];
        n2 = 0; d2 = -1;
        num = 32'hBE800000; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (ld_acc2 && n2 < 4) begin c2[n2] = cf2; t2[n2] = t; n2++; end
            if (done2) begin d2 = t; break; end
        end
        checks++; if (d2 !== 10) begin failures++; $display("FAIL small_latency got %0d req 10", d2); end
        checks++; if (n2 !== 3) begin failures++; $display("FAIL small_pulses got %0d req 3", n2); end
        for (int i = 0; i < 3 && i < n2; i++) begin
            checks++; if (c2[i] !== exp2[i]) begin failures++; $display("FAIL small_cf[%0d] got %h req %h", i, c2[i], exp2[i]); end
        end
        for (int i = 1; i < 3 && i < n2; i++) begin
            checks++; if (t2[i] - t2[i-1] !== 4) begin failures++; $display("FAIL small_gap[%0d] got %0d req 4", i, t2[i] - t2[i-1]); end
        end
        checks++; if (err2 !== 1'b0) begin failures++; $display("FAIL small_err got %b req 0", err2); end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++; if (done2 !== 1'b0) begin failures++; $display("FAIL small_ack got %b req 0", done2); end
    endtask

    initial begin
        test_reset();
        test_valid_half();
        test_range_error();
        test_hold_and_ignore();
        test_reset_mid_run();
        test_small_config();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ln_cu.md
Name: ln_cu

Overview:
- Control unit for the single-precision ln(1+x) accelerator. It is the inverse-function companion of the e^x series sequencer.
- Latches the operand and checks its range.
- Sequences a Horner evaluation of ln(1+x) = x(1 + x(-1/2 + x(1/3 - ...))) over an external FP multiplier, FP adder and accumulator datapath.
- Drives IEEE-754 coefficients, mux select, load strobes and datapath resets, with a start/done/ack handshake toward the requester.

Parameters:
N_TERMS, 8, number of series terms; legal range 2..8.
MUL_LAT, 1, cycles the FP multiplier needs before its output is valid; legal range 1..4.

Ports:
clk  in  1  clock; all logic updates on posedge.
res  in  1  reset, synchronous, active-low; res=0 at a posedge resets the block.
num  in  32  operand x, IEEE-754 single; sampled with start.
start  in  1  request; honoured only in IDLE.
ack  in  1  requester consumed the result; clears done.
x  out  32  latched operand, fed to the multiplier B input.
cf  out  32  coefficient, fed to the adder B input.
m0  out  1  adder A select: 0 = zero, 1 = multiplier output.
ld_acc  out  1  one-cycle strobe: accumulator <= adder output.
resM  out  1  multiplier pipeline clear.
resA  out  1  adder/accumulator clear.
busy  out  1  high from start acceptance until DONE/ERR is entered.
done  out  1  result (or error) available; held until ack.
err  out  1  operand out of range; valid while done=1.

Behaviour:
- Reset (res=0 at posedge), which wins over all other inputs including mid-operation:
  - state <= IDLE.
  - x, cf <= 0.
  - m0, ld_acc, busy, done, err <= 0.
  - resM, resA <= 1 while res=0; they fall at the first posedge with res=1.
- Coefficient table c_k = (-1)^(k+1)/k:
  - c1=3F800000, c2=BF000000, c3=3EAAAAAB, c4=BE800000
  - c5=3E4CCCCD, c6=BE2AAAAB, c7=3E124925, c8=BE000000
- States:
  - IDLE: busy=0.
    - start=1: x<=num, go LOAD.
    - Otherwise all strobes stay 0 and x holds.
  - LOAD: busy=1, resM=resA=1 for this cycle only.
    - Range check: |x|<1 is true iff x[30:23] < 8'd127. This accepts ±0 and denormals; it rejects ±1.0 and above, Inf and NaN.
    - Fail: go ERR. Pass: go SEED.
  - SEED: cf=c_N, m0=0, ld_acc=1 (acc = c_N). k <= N_TERMS-1. Go MUL.
  - MUL: cf=c_k (or 0 when k=0), m0=1, ld_acc=0. Stay exactly MUL_LAT cycles, then go ADD.
  - ADD: cf held, m0=1, ld_acc=1 for one cycle (acc = acc*x + cf).
    - k>0: k<=k-1, go MUL.
    - k=0: go DONE. This is the final pass, acc = acc*x + 0.
  - DONE: busy=0, done=1, cf=0, m0=0. Hold until ack=1, then go IDLE with done cleared on that edge.
  - ERR: busy=0, done=1, err=1. No ld_acc is ever issued. Clears on ack like DONE.
- Timing and sequence:
  - Latency from the posedge sampling start to the first cycle of done=1: 2 + N_TERMS*(MUL_LAT+1) cycles, which is 18 at defaults.
  - Error latency: done=1 two cycles after start.
  - Exactly N_TERMS+1 ld_acc pulses per valid operation.
  - cf sequence at the ld_acc pulses: c_N, c_{N-1}, ..., c_1, 0.
- Handshake rules:
  - start outside IDLE is ignored; it is not queued.
  - ack outside DONE/ERR is ignored.
  - In DONE, ack and start arriving in the same cycle: go IDLE only; the start is dropped.
  - x is stable from LOAD through DONE.
- Parameters outside their legal range are an elaboration error (generate-time check).

Test Plan:
- res=0 for 2 cycles, then release -> all outputs 0 except resM=resA=1 during reset, both 0 one cycle after release; busy=0.
- num=3F000000 (0.5), start pulse, defaults -> done rises 18 cycles later; 9 ld_acc pulses with cf = BE000000, 3E124925, BE2AAAAB, 3E4CCCCD, BE800000, 3EAAAAAB, BF000000, 3F800000, 00000000; m0=0 only on the first pulse; err=0.
- num=3F800000 (1.0), then num=7FC00000 (NaN) -> each gives done=err=1 two cycles after start, no ld_acc; ack clears both next edge.
- Valid run; hold ack=0 for 10 cycles after done; pulse start mid-run -> done stays high, state unchanged, start has no effect; ack -> IDLE.
- res=0 during the 5th MUL cycle -> next edge busy=0, ld_acc=0, cf=0; a new start after release produces a full, correct 18-cycle sequence.
- N_TERMS=2, MUL_LAT=3, num=BE800000 (-0.25) -> done 10 cycles after start; ld_acc cf sequence BF000000, 3F800000, 00000000; consecutive ld_acc pulses 4 cycles apart.
